// File: rtl/rr_bus_arbiter_if.sv
// Shared-bus bundle between NCORES cores, the arbiter and the system bus.
// Core k occupies slice k of every per-core vector.
interface rr_bus_arbiter_if #(
   parameter int NCORES = 2,
   parameter int AW     = 32,
   parameter int DW     = 32
);
   localparam int GW = (NCORES > 1) ? $clog2(NCORES) : 1;

   logic [NCORES-1:0]    i_req;
   logic [NCORES-1:0]    i_idle;
   logic [NCORES*AW-1:0] i_paddr;
   logic [NCORES-1:0]    i_we;
   logic [NCORES*DW-1:0] i_wdata;
   logic [DW-1:0]        i_rdata;
   logic [AW-1:0]        o_paddr;
   logic                 o_we;
   logic [DW-1:0]        o_wdata;
   logic [NCORES*DW-1:0] o_rdata;
   logic [NCORES-1:0]    o_busy;
   logic [GW-1:0]        o_grant;
   logic [NCORES-1:0]    o_grant_oh;
   logic [31:0]          o_switch_cnt;

   modport slave (
      input  i_req, i_idle, i_paddr, i_we, i_wdata, i_rdata,
      output o_paddr, o_we, o_wdata, o_rdata, o_busy,
      output o_grant, o_grant_oh, o_switch_cnt
   );

   modport master (
      output i_req, i_idle, i_paddr, i_we, i_wdata, i_rdata,
      input  o_paddr, o_we, o_wdata, o_rdata, o_busy,
      input  o_grant, o_grant_oh, o_switch_cnt
   );
endinterface

// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter: ownership rotates at instruction boundaries.
// Define RR_ARB_STATS_EN to enable the o_switch_cnt ownership-change counter.
module rr_bus_arbiter #(
   parameter int NCORES  = 2,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int QUANTUM = 1
) (
   input logic CLK,
   input logic RST_X,
   input logic w_init_done,
   input logic w_sys_busy,
   rr_bus_arbiter_if.slave bus
);
   localparam int GW = (NCORES > 1) ? $clog2(NCORES) : 1;
   localparam int CW = $clog2(QUANTUM + 1);

   logic [GW-1:0] grant;
   logic          live;

   generate
      if (NCORES == 1) begin : g_single
         assign grant            = '0;
         assign live             = 1'b1;
         assign bus.o_switch_cnt = 32'h0;
      end else begin : g_multi
         typedef enum logic [1:0] {
            S_WAIT,
            S_DRAIN,
            S_SWITCH,
            S_RUN
         } state_t;

         state_t        state, state_nxt;
         logic [GW-1:0] grant_r, grant_nxt, next;
         logic [CW-1:0] cnt, cnt_nxt;

         // Search starts one past the owner so requesters are served in rotation.
         always_comb begin
            int   idx;
            logic found;
            next  = grant_r;
            found = 1'b0;
            idx   = 0;
            for (int k = 1; k < NCORES; k++) begin
               idx = (int'(grant_r) + k) % NCORES;
               if (!found && bus.i_req[idx]) begin
                  next  = GW'(idx);
                  found = 1'b1;
               end
            end
         end

         always_comb begin
            state_nxt = state;
            grant_nxt = grant_r;
            cnt_nxt   = cnt;
            unique case (state)
               S_WAIT: begin
                  if (bus.i_idle[grant_r])
                     state_nxt = S_DRAIN;
               end
               S_DRAIN: begin
                  grant_nxt = next;
                  state_nxt = S_SWITCH;
               end
               S_SWITCH: begin
                  cnt_nxt   = '0;
                  state_nxt = S_RUN;
               end
               S_RUN: begin
                  if (cnt < CW'(QUANTUM))
                     cnt_nxt = cnt + CW'(1);
                  else
                     state_nxt = S_WAIT;
               end
               default: state_nxt = S_WAIT;
            endcase
         end

         always_ff @(posedge CLK or negedge RST_X) begin
            if (!RST_X) begin
               state   <= S_WAIT;
               grant_r <= '0;
               cnt     <= '0;
            end else if (w_init_done) begin
               state   <= state_nxt;
               grant_r <= grant_nxt;
               cnt     <= cnt_nxt;
            end
         end

         assign grant = grant_r;
         assign live  = (state == S_WAIT) || (state == S_RUN);

`ifdef RR_ARB_STATS_EN
         logic [31:0] sw_cnt;

         always_ff @(posedge CLK or negedge RST_X) begin
            if (!RST_X)
               sw_cnt <= 32'h0;
            else if (w_init_done && state == S_DRAIN && next != grant_r)
               sw_cnt <= sw_cnt + 32'd1;
         end

         assign bus.o_switch_cnt = sw_cnt;
`else
         assign bus.o_switch_cnt = 32'h0;
`endif
      end
   endgenerate

   // Non-owners always stall and see zero read data.
   always_comb begin
      bus.o_paddr    = bus.i_paddr[int'(grant)*AW +: AW];
      bus.o_we       = bus.i_we[grant];
      bus.o_wdata    = bus.i_wdata[int'(grant)*DW +: DW];
      bus.o_grant    = grant;
      bus.o_busy     = '1;
      bus.o_grant_oh = '0;
      bus.o_rdata    = '0;
      for (int k = 0; k < NCORES; k++) begin
         if (k == int'(grant)) begin
            bus.o_busy[k]            = live ? w_sys_busy : 1'b1;
            bus.o_grant_oh[k]        = 1'b1;
            bus.o_rdata[k*DW +: DW]  = bus.i_rdata;
         end
      end
   end
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench: 4-core arbiter with QUANTUM=3 plus a single-core instance.
// Owner busy pattern per rotation: WAIT 0, DRAIN 1, SWITCH 1, RUN 0 x4.
module tb_rr_bus_arbiter;
   logic CLK = 1'b0;
   logic RST_X;
   logic init_done;
   logic sys_busy;
   int   vecs = 0;
   int   errs = 0;
   int   exp_sw = 0;

   always #5 CLK = ~CLK;

   rr_bus_arbiter_if #(.NCORES(4), .AW(32), .DW(32)) bus4 ();
   rr_bus_arbiter_if #(.NCORES(1), .AW(32), .DW(32)) bus1 ();

   rr_bus_arbiter #(.NCORES(4), .AW(32), .DW(32), .QUANTUM(3)) u_dut (
      .CLK         (CLK),
      .RST_X       (RST_X),
      .w_init_done (init_done),
      .w_sys_busy  (sys_busy),
      .bus         (bus4)
   );

   rr_bus_arbiter #(.NCORES(1), .AW(32), .DW(32), .QUANTUM(1)) u_one (
      .CLK         (CLK),
      .RST_X       (RST_X),
      .w_init_done (init_done),
      .w_sys_busy  (sys_busy),
      .bus         (bus1)
   );

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] own(input int k);
      return 4'hF & ~(4'b0001 << k);
   endfunction

   task automatic note_switch(input int from, input int to);
`ifdef RR_ARB_STATS_EN
      if (from != to) exp_sw++;
`endif
   endtask

   // Enters in S_WAIT with i_idle all high; leaves in S_WAIT.
   task automatic run_switch(input int from, input int to);
      logic [127:0] erd;
      chk("wait_grant", 128'(bus4.o_grant), 128'(from));
      chk("wait_busy", 128'(bus4.o_busy), 128'(own(from)));
      cyc();
      chk("drain_grant", 128'(bus4.o_grant), 128'(from));
      chk("drain_busy", 128'(bus4.o_busy), 128'(4'hF));
      cyc();
      note_switch(from, to);
      chk("sw_grant", 128'(bus4.o_grant), 128'(to));
      chk("sw_oh", 128'(bus4.o_grant_oh), 128'(4'b0001 << to));
      chk("sw_busy", 128'(bus4.o_busy), 128'(4'hF));
      chk("sw_cnt", 128'(bus4.o_switch_cnt), 128'(exp_sw));
      for (int r = 0; r < 4; r++) begin
         cyc();
         chk("run_busy", 128'(bus4.o_busy), 128'(own(to)));
      end
      erd = 128'(bus4.i_rdata) << (32 * to);
      chk("run_paddr", 128'(bus4.o_paddr), 128'(32'h1000_0000 + to));
      chk("run_wdata", 128'(bus4.o_wdata), 128'(32'h2000_0000 + to));
      chk("run_we", 128'(bus4.o_we), 128'((4'b1010 >> to) & 4'b1));
      chk("run_rdata", bus4.o_rdata, erd);
      cyc();
   endtask

   initial begin
      RST_X        = 1'b0;
      init_done    = 1'b0;
      sys_busy     = 1'b1;
      bus4.i_req   = 4'b0000;
      bus4.i_idle  = 4'b0000;
      bus4.i_we    = 4'b1010;
      bus4.i_rdata = 32'hCAFE_0000;
      for (int k = 0; k < 4; k++) begin
         bus4.i_paddr[k*32 +: 32] = 32'h1000_0000 + k;
         bus4.i_wdata[k*32 +: 32] = 32'h2000_0000 + k;
      end
      bus1.i_req   = 1'b1;
      bus1.i_idle  = 1'b1;
      bus1.i_we    = 1'b1;
      bus1.i_paddr = 32'hABCD_0000;
      bus1.i_wdata = 32'h1234_5678;
      bus1.i_rdata = 32'h0000_0055;
      #3;
      chk("rst_grant", 128'(bus4.o_grant), 128'(0));
      chk("rst_busy_sb1", 128'(bus4.o_busy), 128'(4'hF));
      chk("rst_swcnt", 128'(bus4.o_switch_cnt), 128'(0));
      sys_busy = 1'b0;
      #1;
      chk("rst_busy_sb0", 128'(bus4.o_busy), 128'(4'hE));
      chk("rst_rdata", bus4.o_rdata, 128'(32'hCAFE_0000));
      chk("rst_paddr", 128'(bus4.o_paddr), 128'(32'h1000_0000));
      chk("one_busy0", 128'(bus1.o_busy), 128'(0));
      cyc();
      RST_X       = 1'b1;
      bus4.i_req  = 4'b1111;
      bus4.i_idle = 4'b1111;
      for (int i = 0; i < 10; i++) cyc();
      chk("frz_grant", 128'(bus4.o_grant), 128'(0));
      chk("frz_busy_sb0", 128'(bus4.o_busy), 128'(4'hE));
      sys_busy = 1'b1;
      #1;
      chk("frz_busy_sb1", 128'(bus4.o_busy), 128'(4'hF));
      chk("one_busy1", 128'(bus1.o_busy), 128'(1));
      chk("one_grant", 128'(bus1.o_grant), 128'(0));
      chk("one_rdata", bus1.o_rdata, 128'(32'h55));
      chk("one_paddr", 128'(bus1.o_paddr), 128'(32'hABCD_0000));
      chk("one_wdata", 128'(bus1.o_wdata), 128'(32'h1234_5678));
      sys_busy  = 1'b0;
      init_done = 1'b1;
      #1;
      run_switch(0, 1);
      run_switch(1, 2);
      run_switch(2, 3);
      run_switch(3, 0);
      bus4.i_req = 4'b1001;
      run_switch(0, 3);
      run_switch(3, 0);
      bus4.i_req = 4'b0001;
      run_switch(0, 0);
      chk("one_swcnt", 128'(bus1.o_switch_cnt), 128'(0));
      bus4.i_req = 4'b0100;
      chk("pre_grant", 128'(bus4.o_grant), 128'(0));
      cyc();
      chk("pre_drain", 128'(bus4.o_busy), 128'(4'hF));
      cyc();
      chk("pre_sw_grant", 128'(bus4.o_grant), 128'(2));
      #2;
      RST_X  = 1'b0;
      exp_sw = 0;
      #1;
      chk("mid_rst_grant", 128'(bus4.o_grant), 128'(0));
      chk("mid_rst_busy", 128'(bus4.o_busy), 128'(4'hE));
      chk("mid_rst_rdata", bus4.o_rdata, 128'(32'hCAFE_0000));
      chk("mid_rst_oh", 128'(bus4.o_grant_oh), 128'(4'b0001));
      chk("mid_rst_swcnt", 128'(bus4.o_switch_cnt), 128'(0));
      cyc();
      RST_X      = 1'b1;
      bus4.i_req = 4'b1111;
      #1;
      run_switch(0, 1);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
